// File: rtl/matrix_result_serializer.sv
// matrix_result_serializer
// Accepts packed 2x2 result matrices over valid/ready into a two-entry
// ping-pong buffer and streams their elements one per handshake in
// row-major order (C11, C12, C21, C22), tagged with row/col and a last flag.
module matrix_result_serializer #(
  parameter int ELEM_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*ELEM_W-1:0] in_mat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ELEM_W-1:0]   out_elem,
  output logic                out_row,
  output logic                out_col,
  output logic                out_last
);

  localparam int MAT_W = 4 * ELEM_W;

  logic [MAT_W-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [1:0]       r_idx;

  logic             w_accept;
  logic             w_pop_elem;
  logic             w_pop_mat;
  logic [MAT_W-1:0] w_cur;

  // Handshake qualifiers; in_ready comes only from registered occupancy so a
  // full buffer never accepts, even on the edge where a matrix pops.
  assign in_ready   = (r_count != 2'd2);
  assign out_valid  = (r_count != 2'd0);
  assign w_accept   = in_valid && in_ready;
  assign w_pop_elem = out_valid && out_ready;
  assign w_pop_mat  = w_pop_elem && (r_idx == 2'd3);
  assign w_cur      = r_mem[r_rd_ptr];

  // Matrix storage: write the incoming word into the entry at wr_ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the two entries are cleared on reset so a discarded stream can
    // never reappear; sequential state is always updated with <= so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (w_accept) begin
      r_mem[r_wr_ptr] <= in_mat;
    end
  end

  // Pointers, occupancy and element index bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_idx    <= 2'd0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop_mat) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Accept and matrix pop on the same edge cancel out.
      r_count <= r_count + {1'b0, w_accept} - {1'b0, w_pop_mat};
      // Index wraps 3 -> 0 naturally, which is exactly the matrix pop case.
      if (w_pop_elem) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  // Element select and tags; all element outputs are zero while idle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    out_elem = '0;
    out_row  = 1'b0;
    out_col  = 1'b0;
    out_last = 1'b0;
    if (out_valid) begin
      case (r_idx)
        2'd0:    out_elem = w_cur[4*ELEM_W-1 -: ELEM_W];
        2'd1:    out_elem = w_cur[3*ELEM_W-1 -: ELEM_W];
        2'd2:    out_elem = w_cur[2*ELEM_W-1 -: ELEM_W];
        default: out_elem = w_cur[ELEM_W-1   -: ELEM_W];
      endcase
      out_row  = r_idx[1];
      out_col  = r_idx[0];
      out_last = (r_idx == 2'd3);
    end
  end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench for matrix_result_serializer (ELEM_W=4).
// Outputs are sampled 1 time unit after each rising edge; inputs are changed
// at the same point so they take effect on the following edge.
module tb_matrix_result_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_mat;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_elem;
  logic        out_row;
  logic        out_col;
  logic        out_last;

  int n_pass  = 0;
  int n_total = 0;

  matrix_result_serializer #(.ELEM_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mat    (in_mat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_elem  (out_elem),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output tuple {valid, elem, row, col, last}.
  function automatic logic [7:0] obs();
    return {out_valid, out_elem, out_row, out_col, out_last};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mat    = '0;
    out_ready = 1'b1;
    #12;
    n_total++;
    if (obs() !== 8'h00) $display("FAIL reset_out got %h exp 00", obs());
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready);
    else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_stream();
    logic [15:0] m;
    logic [3:0]  e [4];
    logic [1:0]  ix;
    m = 16'hF13A;
    e[0] = 4'd15; e[1] = 4'd1; e[2] = 4'd3; e[3] = 4'd10;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mat    = m;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ix = i[1:0];
      n_total++;
      if (obs() !== {1'b1, e[i], ix[1], ix[0], (i == 3)})
        $display("FAIL basic_elem%0d got %h exp %h", i, obs(), {1'b1, e[i], ix[1], ix[0], (i == 3)});
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL basic_in_ready%0d got %b exp 1", i, in_ready);
      else n_pass++;
      step();
    end
    n_total++;
    if (obs() !== 8'h00) $display("FAIL basic_idle got %h exp 00", obs());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_t [4];
    logic [7:0] cur;
    logic [7:0] prev;
    logic       prev_rdy;
    int         k;
    exp_t[0] = {1'b1, 4'd15, 1'b0, 1'b0, 1'b0};
    exp_t[1] = {1'b1, 4'd1,  1'b0, 1'b1, 1'b0};
    exp_t[2] = {1'b1, 4'd3,  1'b1, 1'b0, 1'b0};
    exp_t[3] = {1'b1, 4'd10, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mat    = 16'hF13A;
    step();
    in_valid = 1'b0;
    k        = 0;
    prev     = '0;
    prev_rdy = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      cur = obs();
      if (prev[7] && !prev_rdy) begin
        n_total++;
        if (cur !== prev) $display("FAIL bp_hold cyc%0d got %h exp %h", cyc, cur, prev);
        else n_pass++;
      end
      out_ready = (cyc % 2 == 0);
      if (cur[7] && out_ready) begin
        n_total++;
        if (k > 3 || cur !== exp_t[k & 3])
          $display("FAIL bp_elem%0d got %h exp %h", k, cur, exp_t[k & 3]);
        else n_pass++;
        k++;
      end
      prev     = cur;
      prev_rdy = out_ready;
      step();
    end
    n_total++;
    if (k !== 4) $display("FAIL bp_count got %0d exp 4", k);
    else n_pass++;
    n_total++;
    if (obs() !== 8'h00) $display("FAIL bp_idle got %h exp 00", obs());
    else n_pass++;
    out_ready = 1'b1;
  endtask

  task automatic test_full_buffer();
    logic [1:0] ix;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mat    = 16'h1234;
    step();
    in_mat = 16'h5678;
    step();
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b exp 0", in_ready);
    else n_pass++;
    in_mat = 16'h9ABC;
    step();
    in_valid = 1'b0;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL full_in_ready_hold got %b exp 0", in_ready);
    else n_pass++;
    n_total++;
    if (obs() !== {1'b1, 4'd1, 1'b0, 1'b0, 1'b0})
      $display("FAIL full_head got %h exp %h", obs(), {1'b1, 4'd1, 1'b0, 1'b0, 1'b0});
    else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ix = i[1:0];
      n_total++;
      if (obs() !== {1'b1, 4'(i + 1), ix[1], ix[0], (ix == 2'd3)})
        $display("FAIL full_elem%0d got %h exp %h", i, obs(), {1'b1, 4'(i + 1), ix[1], ix[0], (ix == 2'd3)});
      else n_pass++;
      n_total++;
      if (in_ready !== (i >= 4)) $display("FAIL full_ready%0d got %b exp %b", i, in_ready, (i >= 4));
      else n_pass++;
      step();
    end
    n_total++;
    if (obs() !== 8'h00) $display("FAIL full_idle got %h exp 00", obs());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] e [8];
    logic [1:0] ix;
    e[0] = 4'h1; e[1] = 4'h2; e[2] = 4'h3; e[3] = 4'h4;
    e[4] = 4'hA; e[5] = 4'hB; e[6] = 4'hC; e[7] = 4'hD;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mat    = 16'h1234;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ix = i[1:0];
      n_total++;
      if (obs() !== {1'b1, e[i], ix[1], ix[0], (ix == 2'd3)})
        $display("FAIL b2b_elem%0d got %h exp %h", i, obs(), {1'b1, e[i], ix[1], ix[0], (ix == 2'd3)});
      else n_pass++;
      if (i == 3) begin
        in_valid = 1'b1;
        in_mat   = 16'hABCD;
      end
      step();
      in_valid = 1'b0;
      if (i == 3) begin
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got %b exp 1", in_ready);
        else n_pass++;
      end
    end
    n_total++;
    if (obs() !== 8'h00) $display("FAIL b2b_idle got %h exp 00", obs());
    else n_pass++;
  endtask

  task automatic test_reset_mid_stream();
    logic [1:0] ix;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mat    = 16'h1234;
    step();
    in_valid = 1'b0;
    step();
    step();
    n_total++;
    if (obs() !== {1'b1, 4'd3, 1'b1, 1'b0, 1'b0})
      $display("FAIL rst_pre got %h exp %h", obs(), {1'b1, 4'd3, 1'b1, 1'b0, 1'b0});
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (obs() !== 8'h00) $display("FAIL rst_async_out got %h exp 00", obs());
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL rst_async_ready got %b exp 1", in_ready);
    else n_pass++;
    #2;
    rst_n = 1'b1;
    step();
    n_total++;
    if (obs() !== 8'h00) $display("FAIL rst_after got %h exp 00", obs());
    else n_pass++;
    in_valid = 1'b1;
    in_mat   = 16'h5678;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ix = i[1:0];
      n_total++;
      if (obs() !== {1'b1, 4'(i + 5), ix[1], ix[0], (i == 3)})
        $display("FAIL rst_elem%0d got %h exp %h", i, obs(), {1'b1, 4'(i + 5), ix[1], ix[0], (i == 3)});
      else n_pass++;
      step();
    end
    n_total++;
    if (obs() !== 8'h00) $display("FAIL rst_idle got %h exp 00", obs());
    else n_pass++;
  endtask

  task automatic test_integration();
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  am [4];
    logic [3:0]  bm [4];
    logic [3:0]  cm [4];
    logic [15:0] c;
    logic [3:0]  e [4];
    logic [1:0]  ix;
    a = 8'h1B;
    b = 8'h4D;
    // Unpack 2-bit operands row-major from the MSB.
    for (int i = 0; i < 4; i++) begin
      am[i] = {2'b00, a[(3 - i) * 2 +: 2]};
      bm[i] = {2'b00, b[(3 - i) * 2 +: 2]};
    end
    cm[0] = am[0] * bm[0] + am[1] * bm[2];
    cm[1] = am[0] * bm[1] + am[1] * bm[3];
    cm[2] = am[2] * bm[0] + am[3] * bm[2];
    cm[3] = am[2] * bm[1] + am[3] * bm[3];
    c = {cm[0], cm[1], cm[2], cm[3]};
    n_total++;
    if (c !== 16'h31B3) $display("FAIL int_model got %h exp 31b3", c);
    else n_pass++;
    e[0] = 4'd3; e[1] = 4'd1; e[2] = 4'd11; e[3] = 4'd3;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mat    = c;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ix = i[1:0];
      n_total++;
      if (obs() !== {1'b1, e[i], ix[1], ix[0], (i == 3)})
        $display("FAIL int_elem%0d got %h exp %h", i, obs(), {1'b1, e[i], ix[1], ix[0], (i == 3)});
      else n_pass++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_full_buffer();
    test_back_to_back();
    test_reset_mid_stream();
    test_integration();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
Receiver for the packed 2x2 result bus produced by matrix_multiply. Accepts a packed matrix word via valid/ready and streams its four elements, one per handshake, in row-major order with row/col tags and a last flag. A two-entry matrix buffer lets the producer hand over the next result while the current one is still streaming. Sits between the matrix compute blocks and any element-serial consumer, such as a display, UART or checker.

Parameters:
ELEM_W, 4, width of one result element. The packed word is 4*ELEM_W bits.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_mat is valid this cycle
in_ready  output  1  block can accept a matrix this cycle
in_mat  input  4*ELEM_W  packed matrix; C11=[4E-1:3E], C12=[3E-1:2E], C21=[2E-1:E], C22=[E-1:0], where E=ELEM_W
out_valid  output  1  out_elem/out_row/out_col/out_last are valid
out_ready  input  1  consumer accepts the current element
out_elem  output  ELEM_W  current element value
out_row  output  1  row index of out_elem
out_col  output  1  column index of out_elem
out_last  output  1  high on the 4th element (C22) of a matrix

Behaviour:
- State: two matrix entries (ping-pong), wr_ptr, rd_ptr, count in {0,1,2}, and element index idx in {0..3}.
- Reset while rst_n=0, applied immediately and not waiting for clk:
  - count=0, idx=0, pointers=0, buffer entries=0.
  - in_ready=1, out_valid=0, out_elem=0, out_row=0, out_col=0, out_last=0.
- Accept: in_valid && in_ready at a rising edge writes in_mat to entry[wr_ptr], toggles wr_ptr, and increments count.
- in_ready = (count != 2). It depends only on registered state, with no combinational path from out_ready.
  - When count==2, a matrix is not accepted even if a pop happens on the same edge. in_ready rises the cycle after the pop.
- Output:
  - out_valid = (count != 0).
  - out_elem is the idx-th element of entry[rd_ptr], counting from the MSB: idx0=C11, idx1=C12, idx2=C21, idx3=C22.
  - out_row = idx[1], out_col = idx[0], out_last = out_valid && (idx==3).
  - When out_valid=0, out_elem/out_row/out_col/out_last are driven 0.
- Element pop: on out_valid && out_ready, idx increments. At idx==3 the matrix pops instead: idx goes to 0, rd_ptr toggles and count decrements.
- Simultaneous accept and matrix pop (count==1): count stays 1. The new matrix begins at idx 0 on the next cycle with no bubble.
- Accept with count==1 and no pop: count goes to 2. The current stream is unaffected.
- Latency: a matrix accepted at edge k, with count==0 before the edge, shows out_valid=1 with element C11 in the cycle after edge k.
- Throughput: 1 element per cycle while out_ready=1. Back-to-back matrices stream with no idle cycle.
- Backpressure: while out_valid && !out_ready, all out_* outputs stay stable. No element is skipped or duplicated.
- Entries are stored unmodified. Element values are transported bit-exact, with no arithmetic.
- Reset mid-stream: buffered and partially streamed matrices are discarded. After reset release, the first accepted matrix streams from C11.

Test Plan:
1. Reset, then push in_mat=0xF13A with out_ready=1 -> consecutive cycles give (15,r0,c0), (1,r0,c1), (3,r1,c0), (10,r1,c1,last=1); out_valid=0 afterwards; in_ready=1 throughout.
2. Push 0xF13A with out_ready toggling 1,0,1,0... -> outputs held stable in the 0 cycles; sequence is exactly 15,1,3,10; last asserted only with 10.
3. out_ready=0; push 0x1234 then 0x5678 -> in_ready=0 after the second accept; a third in_valid with 0x9ABC is not taken. Raise out_ready -> stream 1,2,3,4,5,6,7,8, with last on 4 and 8. in_ready returns to 1 the cycle after 4 is popped.
4. count==1, streaming 0x1234; assert in_valid with 0xABCD on the edge where element 4 (last) is popped -> count stays 1; the next cycle shows 10 (0xA) at r0,c0; no gap.
5. Assert rst_n=0 mid-cycle after 2 of 4 elements of 0x1234 -> outputs go to reset values immediately, without a clock edge. After release, push 0x5678 -> stream 5,6,7,8.
6. Integration: matrix_multiply with A=0x1B, B=0x4D produces C=0x31B3. Feed it in -> stream 3,1,11,3 with indices (0,0),(0,1),(1,0),(1,1).
